// File: rtl/quad_gen_if.sv
// rtl/quad_gen_if.sv - step command channel between a command source and quad_gen
// Ports (interface members):
//   cmd_valid   command request from the source
//   cmd_ready   generator idle and able to take a command
//   cmd_dir     1 = count up (CW), 0 = count down (CCW)
//   cmd_steps   number of quadrature edges to emit
//   cmd_period  clocks between edges, 0 behaves as 1
// Modports: master (command source), slave (generator).
interface quad_gen_if #(
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEPS_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_gen.sv
// rtl/quad_gen.sv - quadrature encoder emulator turning step commands into A/B/Z
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active low
//   cmd        step command channel (quad_gen_if.slave)
//   abort      stop the running command at the next clock, no done pulse
//   A, B       registered quadrature outputs (Gray sequence 00,01,11,10)
//   Z          registered index, high while the index counter is 0
//   position   emulated count, 16-bit two's-complement wrap
//   busy       command in progress
//   done       one-cycle pulse when a command completes normally
module quad_gen #(
  parameter int CPR      = 4096,
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  quad_gen_if.slave   cmd,
  input  logic        abort,
  output logic        A,
  output logic        B,
  output logic        Z,
  output logic [15:0] position,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = $clog2(CPR);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic                dir_q;
  logic [STEPS_W-1:0]  steps_left;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] per_cnt;
  logic [1:0]          phase;
  logic [IDX_W-1:0]    idx_cnt;

  logic                accept;
  logic                step;
  logic                done_next;
  logic [1:0]          phase_step;
  logic [IDX_W-1:0]    idx_step;
  logic [15:0]         pos_step;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Abort wins over an expiring period: the run simply stops with outputs held.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          accept = 1'b1;
          if (cmd.cmd_steps != '0) state_next = RUN;
          else                     done_next  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (per_cnt == period_q - PERIOD_W'(1)) begin
          step = 1'b1;
          if (steps_left == STEPS_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    phase_step = dir_q ? phase + 2'd1 : phase - 2'd1;
    pos_step   = dir_q ? position + 16'd1 : position - 16'd1;
    if (dir_q) idx_step = (idx_cnt == IDX_MAX) ? '0 : idx_cnt + IDX_W'(1);
    else       idx_step = (idx_cnt == '0) ? IDX_MAX : idx_cnt - IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q      <= 1'b0;
      steps_left <= '0;
      period_q   <= PERIOD_W'(1);
      per_cnt    <= '0;
      phase      <= 2'd0;
      idx_cnt    <= '0;
      A          <= 1'b0;
      B          <= 1'b0;
      Z          <= 1'b1;
      position   <= 16'd0;
      done       <= 1'b0;
    end else begin
      done <= done_next;
      if (accept) begin
        dir_q      <= cmd.cmd_dir;
        steps_left <= cmd.cmd_steps;
        period_q   <= (cmd.cmd_period == '0) ? PERIOD_W'(1) : cmd.cmd_period;
        per_cnt    <= '0;
      end else if (step) begin
        per_cnt    <= '0;
        steps_left <= steps_left - STEPS_W'(1);
        phase      <= phase_step;
        // phase 0..3 maps onto the Gray code 00,01,11,10
        A          <= phase_step[1];
        B          <= phase_step[1] ^ phase_step[0];
        position   <= pos_step;
        idx_cnt    <= idx_step;
        Z          <= (idx_step == '0);
      end else if (state == RUN && !abort) begin
        per_cnt    <= per_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// tb/tb_quad_gen.sv - self-checking bench for quad_gen
module tb_quad_gen;

  localparam int CPR_M = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort_m = 1'b0;
  logic        abort8 = 1'b0;
  logic        A_m, B_m, Z_m, busy_m, done_m;
  logic        A8, B8, Z8, busy8, done8;
  logic [15:0] pos_m, pos8;

  quad_gen_if #(.STEPS_W(16), .PERIOD_W(16)) if_m ();
  quad_gen_if #(.STEPS_W(16), .PERIOD_W(16)) if8 ();

  quad_gen #(.CPR(CPR_M), .STEPS_W(16), .PERIOD_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd(if_m), .abort(abort_m),
    .A(A_m), .B(B_m), .Z(Z_m), .position(pos_m), .busy(busy_m), .done(done_m)
  );

  quad_gen #(.CPR(8), .STEPS_W(16), .PERIOD_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cmd(if8), .abort(abort8),
    .A(A8), .B(B8), .Z(Z8), .position(pos8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ph_m  = 0;
  int idx_m = 0;

  // Reference quadrature decoder watching the CPR=8 instance.
  int         dec_cnt;
  int         dec_illegal;
  logic [1:0] dec_prev;

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt     <= 0;
      dec_illegal <= 0;
      dec_prev    <= 2'b00;
    end else begin
      dec_prev <= {A8, B8};
      case ((ph_of({A8, B8}) - ph_of(dec_prev)) & 3)
        1:       dec_cnt     <= dec_cnt + 1;
        3:       dec_cnt     <= dec_cnt - 1;
        2:       dec_illegal <= dec_illegal + 1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ph_m  = 0;
    idx_m = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_A"}, A_m, 0);
    check({tag, "_B"}, B_m, 0);
    check({tag, "_Z"}, Z_m, 1);
    check({tag, "_position"}, pos_m, 0);
    check({tag, "_cmd_ready"}, if_m.cmd_ready, 1);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_done"}, done_m, 0);
  endtask

  // Issues one command and watches every cycle after the accepting edge.
  task automatic do_cmd(input logic dir, input int steps, input int period,
                        input int abort_after, input logic abort_with_valid,
                        output int edges, output int dones, output int bad_gray,
                        output int bad_seq, output int bad_timing);
    int         p_eff;
    int         abort_k;
    int         waited;
    logic [1:0] prev_ab;
    logic [1:0] ab;
    p_eff      = (period == 0) ? 1 : period;
    edges      = 0;
    dones      = 0;
    bad_gray   = 0;
    bad_seq    = 0;
    bad_timing = 0;
    abort_k    = -1;
    waited     = 0;
    while (!if_m.cmd_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!if_m.cmd_ready) check("wait_cmd_ready", 0, 1);
    prev_ab = {A_m, B_m};
    if_m.cmd_valid  = 1'b1;
    if_m.cmd_dir    = dir;
    if_m.cmd_steps  = 16'(steps);
    if_m.cmd_period = 16'(period);
    abort_m         = abort_with_valid;
    @(posedge clk);
    #1;
    if_m.cmd_valid = 1'b0;
    abort_m        = 1'b0;
    for (int k = 0; k <= steps * p_eff + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      ab = {A_m, B_m};
      if (k == abort_k) begin
        abort_m = 1'b0;
        if (!if_m.cmd_ready) bad_timing++;
      end
      if (ab != prev_ab) begin
        edges++;
        if ((ab ^ prev_ab) == 2'b11) bad_gray++;
        if (k != edges * p_eff) bad_timing++;
        ph_m  = dir ? (ph_m + 1) % 4 : (ph_m + 3) % 4;
        idx_m = dir ? (idx_m + 1) % CPR_M : (idx_m + CPR_M - 1) % CPR_M;
        if (ab != ab_of(ph_m)) bad_seq++;
        if (abort_after > 0 && edges == abort_after) begin
          abort_m = 1'b1;
          abort_k = k + 1;
        end
      end
      if (Z_m != (idx_m == 0)) bad_seq++;
      if (done_m) begin
        dones++;
        if (k != steps * p_eff || !if_m.cmd_ready) bad_timing++;
      end
      prev_ab = ab;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        dir;
    int          steps;
    int          period;
    int          abort_after;
    logic        abort_with_valid;
    int          exp_edges;
    int          exp_dones;
    logic [15:0] exp_pos;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int edges, dones, bad_gray, bad_seq, bad_timing;
    int z_bad, z_rises, done8_cnt;
    logic z_prev;

    //          rst   dir   steps per abort avw   edges dones pos
    vecs[0] = '{1'b1, 1'b1, 8,    2,  0,    1'b0, 8,    1,    16'h0008};
    vecs[1] = '{1'b1, 1'b0, 4,    1,  0,    1'b0, 4,    1,    16'hFFFC};
    vecs[2] = '{1'b0, 1'b1, 0,    5,  0,    1'b0, 0,    1,    16'hFFFC};
    vecs[3] = '{1'b0, 1'b1, 3,    0,  0,    1'b0, 3,    1,    16'hFFFF};
    vecs[4] = '{1'b0, 1'b1, 3,    1,  0,    1'b0, 3,    1,    16'h0002};
    vecs[5] = '{1'b1, 1'b1, 10,   4,  3,    1'b0, 3,    0,    16'h0003};
    vecs[6] = '{1'b0, 1'b0, 5,    3,  0,    1'b0, 5,    1,    16'hFFFE};
    vecs[7] = '{1'b0, 1'b1, 10,   1,  2,    1'b0, 2,    0,    16'h0000};
    vecs[8] = '{1'b0, 1'b1, 2,    1,  0,    1'b1, 2,    1,    16'h0002};

    if_m.cmd_valid  = 1'b0;
    if_m.cmd_dir    = 1'b0;
    if_m.cmd_steps  = '0;
    if_m.cmd_period = '0;
    if8.cmd_valid   = 1'b0;
    if8.cmd_dir     = 1'b0;
    if8.cmd_steps   = '0;
    if8.cmd_period  = '0;

    do_reset();
    check_reset_values("reset");

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      do_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].abort_after,
             vecs[i].abort_with_valid, edges, dones, bad_gray, bad_seq, bad_timing);
      check($sformatf("v%0d_edges", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_dones", i), dones, vecs[i].exp_dones);
      check($sformatf("v%0d_gray", i), bad_gray, 0);
      check($sformatf("v%0d_ab_z_seq", i), bad_seq, 0);
      check($sformatf("v%0d_timing", i), bad_timing, 0);
      check($sformatf("v%0d_position", i), pos_m, vecs[i].exp_pos);
    end

    // Reset asserted while a command is running.
    if_m.cmd_valid  = 1'b1;
    if_m.cmd_dir    = 1'b1;
    if_m.cmd_steps  = 16'd10;
    if_m.cmd_period = 16'd2;
    @(posedge clk);
    #1;
    if_m.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrun_busy", busy_m, 1);
    do_reset();
    check_reset_values("midrun_reset");
    repeat (3) @(posedge clk);
    #1;
    check("midrun_stays_idle_pos", pos_m, 0);

    // CPR=8 instance checked against the reference decoder.
    do_reset();
    z_bad     = 0;
    z_rises   = 0;
    done8_cnt = 0;
    z_prev    = Z8;
    check("cpr8_z_at_reset", Z8, 1);
    if8.cmd_valid  = 1'b1;
    if8.cmd_dir    = 1'b1;
    if8.cmd_steps  = 16'd16;
    if8.cmd_period = 16'd3;
    @(posedge clk);
    #1;
    if8.cmd_valid = 1'b0;
    for (int k = 0; k < 16 * 3 + 6; k++) begin
      @(posedge clk);
      #1;
      if (Z8 != (pos8[2:0] == 3'd0)) z_bad++;
      if (Z8 && !z_prev) z_rises++;
      if (done8) done8_cnt++;
      z_prev = Z8;
    end
    check("cpr8_z_vs_position", z_bad, 0);
    check("cpr8_z_rises", z_rises, 2);
    check("cpr8_position", pos8, 16);
    check("cpr8_decoder_count", dec_cnt, 16);
    check("cpr8_decoder_illegal", dec_illegal, 0);
    check("cpr8_done_pulses", done8_cnt, 1);
    check("cpr8_busy_end", busy8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
